instr_fetch_ctrl: RTL and testbench
===================================

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 Parameter IMEM_WORDS, default 81: instruction memory depth in 32-bit words; the fetch limit is IMEM_WORDS*4.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port fetch_en  input  1: when 1, fetching is permitted; when 0, new fetches stop.
REQ-006 Port redirect_valid  input  1: one-cycle request to restart fetch at redirect_pc.
REQ-007 Port redirect_pc  input  32: byte address of the new fetch target.
REQ-008 Port imem_addr  output  32: byte address driven to instruction memory, equal to the internal PC.
REQ-009 Port imem_data  input  32: instruction word returned combinationally for imem_addr in the same cycle.
REQ-010 Port if_valid  output  1: the buffer head holds a valid instruction.
REQ-011 Port if_ready  input  1: the consumer accepts the head when if_valid && if_ready.
REQ-012 Port if_pc  output  32: PC of the head entry.
REQ-013 Port if_instr  output  32: instruction word of the head entry.
REQ-014 Port fetch_done  output  1: PC has reached the fetch limit (DONE state).
REQ-015 Port fetch_err  output  1: sticky flag set by a misaligned or out-of-range redirect (HALT state).
REQ-016 Port fetch_count  output  16: number of pushed instructions, saturating at 16'hFFFF.

Function
REQ-017 The FSM SHALL have four states: IDLE, RUN, DONE and HALT.
- IDLE->RUN when fetch_en=1.
- RUN->IDLE when fetch_en=0.
- RUN->DONE when PC+4 = IMEM_WORDS*4 on a push.
- Any state->HALT on a bad redirect.
REQ-018 A push in RUN SHALL capture {PC, imem_data} into a 2-entry FIFO and advance PC by 4 in the same cycle; latency from PC to if_valid is 1 cycle.
REQ-019 A push SHALL occur only when count<2, or when count=2 and a pop occurs in the same cycle.
REQ-020 Pop (if_valid && if_ready) SHALL remove the head; simultaneous push and pop SHALL leave count unchanged, and order is preserved.
REQ-021 if_pc and if_instr SHALL hold stable while if_valid=1 and if_ready=0.
REQ-022 An aligned, in-range redirect_valid SHALL have these effects on that edge:
- flush the FIFO (count=0);
- set PC to redirect_pc;
- suppress any push that cycle;
- return DONE/IDLE to RUN if fetch_en=1, otherwise to IDLE.
Redirect priority is over push and pop.
REQ-023 A redirect with redirect_pc[1:0]!=0 or redirect_pc>=IMEM_WORDS*4 SHALL flush the FIFO, set fetch_err=1 and enter HALT.
REQ-024 HALT SHALL exit only through reset; no pushes occur in HALT.
REQ-025 In DONE and IDLE, no pushes SHALL occur and existing entries SHALL remain poppable.
REQ-026 fetch_done SHALL be 1 exactly while the state is DONE.
REQ-027 fetch_count SHALL increment by 1 per push and SHALL not wrap.
REQ-028 imem_addr SHALL always equal PC, including in non-fetching states.

Reset
REQ-029 On rst_n=0, the block SHALL immediately take these values:
- state=IDLE, PC=RESET_PC, count=0;
- if_valid=0, if_pc=0, if_instr=0;
- fetch_done=0, fetch_err=0, fetch_count=0.
REQ-030 Reset asserted mid-stream SHALL discard buffered entries.
REQ-031 The first push after release SHALL occur on the first edge with fetch_en=1.

Verification
REQ-032 Streaming: reset, fetch_en=1, if_ready=1 -> if_pc sequence 0,4,8,... one per cycle; if_instr matches memory words 0,1,2 (32'h00000093, 32'h00100113, 32'h00102023).
REQ-033 Backpressure: if_ready=0 for 5 cycles -> count=2, if_pc=0 held, imem_addr=8; after if_ready=1 -> 0,4,8 in order with no loss or duplication.
REQ-034 Redirect: redirect_pc=32'h40 while count=2 -> next cycle if_valid=0; following cycle if_pc=32'h40.
REQ-035 Bad redirect: redirect_pc=32'h42 -> fetch_err=1, state HALT, if_valid=0, no further pushes until reset.
REQ-036 Limit: IMEM_WORDS=81, run to end -> last if_pc=32'h140 (320), fetch_done=1, fetch_count=81.
REQ-037 Limit recovery: redirect_pc=0 from DONE -> fetch restarts at 0 and fetch_done=0.
REQ-038 Reset mid-stream: assert rst_n=0 while count=2 -> if_valid=0 asynchronously; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction fetch controller with 2-entry fetch buffer
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 81
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_done,
    output logic        fetch_err,
    output logic [15:0] fetch_count
);

    localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_HALT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        err_q;
    logic [15:0] fcount_q;

    logic        redir_bad;
    logic        redir_ok;
    logic        pop;
    logic        push;
    logic        at_last;

    always_comb begin
        redir_bad = redirect_valid && ((redirect_pc[1:0] != 2'b00) || (redirect_pc >= LIMIT));
        redir_ok  = redirect_valid && !redir_bad && (state_q != S_HALT);
        pop       = (count != 2'd0) && if_ready;
        at_last   = (pc_q + 32'd4) == LIMIT;
        // IDLE with fetch_en high fetches on the same edge it enters RUN
        push      = fetch_en && !redirect_valid
                    && ((state_q == S_RUN) || (state_q == S_IDLE))
                    && ((count != 2'd2) || pop);
    end

    always_comb begin
        state_d = state_q;
        if (redir_bad) begin
            state_d = S_HALT;
        end else if (redir_ok) begin
            state_d = fetch_en ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_en) begin
                        state_d = (push && at_last) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!fetch_en) begin
                        state_d = S_IDLE;
                    end else if (push && at_last) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_DONE;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirects, good or bad, take priority over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            err_q    <= 1'b0;
            fcount_q <= 16'h0000;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= 32'h0;
                fifo_instr[i] <= 32'h0;
            end
        end else if (redir_bad) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            err_q  <= 1'b1;
        end else if (redir_ok) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            pc_q   <= redirect_pc;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= pc_q;
                fifo_instr[wr_ptr] <= imem_data;
                wr_ptr             <= ~wr_ptr;
                pc_q               <= pc_q + 32'd4;
                if (fcount_q != 16'hFFFF) begin
                    fcount_q <= fcount_q + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = (count != 2'd0);
    assign if_pc       = fifo_pc[rd_ptr];
    assign if_instr    = fifo_instr[rd_ptr];
    assign fetch_done  = (state_q == S_DONE);
    assign fetch_err   = err_q;
    assign fetch_count = fcount_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed self-checking bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_done;
    logic        fetch_err;
    logic [15:0] fetch_count;

    logic [31:0] mem [81];
    int checks = 0;
    int errors = 0;

    instr_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(81)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fetch_done     (fetch_done),
        .fetch_err      (fetch_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        imem_data = 32'h0;
        if (imem_addr < 32'd324) imem_data = mem[imem_addr[8:2]];
    end

    function automatic logic [31:0] word_at(input int idx);
        case (idx)
            0:       return 32'h00000093;
            1:       return 32'h00100113;
            2:       return 32'h00102023;
            default: return 32'h13000000 + 32'(idx);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    logic [31:0] last_pc;
    logic [15:0] saved_cnt;

    initial begin
        for (int i = 0; i < 81; i++) mem[i] = word_at(i);

        // reset values
        rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
        #1;
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_done", {31'b0, fetch_done}, 32'h0);
        check("rst_err", {31'b0, fetch_err}, 32'h0);
        check("rst_count", {16'b0, fetch_count}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // streaming
        do_reset();
        fetch_en = 1'b1; if_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("stream_valid", {31'b0, if_valid}, 32'h1);
            check("stream_pc", if_pc, 32'(k * 4));
            check("stream_instr", if_instr, word_at(k));
        end

        // backpressure
        do_reset();
        fetch_en = 1'b1; if_ready = 1'b0;
        step(5);
        check("bp_valid", {31'b0, if_valid}, 32'h1);
        check("bp_pc_held", if_pc, 32'h0);
        check("bp_addr", imem_addr, 32'h8);
        check("bp_count", {16'b0, fetch_count}, 32'd2);
        if_ready = 1'b1;
        step(1);
        check("bp_pc1", if_pc, 32'h4);
        check("bp_instr1", if_instr, word_at(1));
        step(1);
        check("bp_pc2", if_pc, 32'h8);
        check("bp_instr2", if_instr, word_at(2));

        // redirect while full
        do_reset();
        fetch_en = 1'b1; if_ready = 1'b0;
        step(3);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step(1);
        redirect_valid = 1'b0;
        check("redir_flush", {31'b0, if_valid}, 32'h0);
        check("redir_addr", imem_addr, 32'h40);
        step(1);
        check("redir_valid", {31'b0, if_valid}, 32'h1);
        check("redir_pc", if_pc, 32'h40);
        check("redir_instr", if_instr, word_at(16));

        // misaligned redirect halts
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step(1);
        redirect_valid = 1'b0;
        check("bad_err", {31'b0, fetch_err}, 32'h1);
        check("bad_flush", {31'b0, if_valid}, 32'h0);
        saved_cnt = fetch_count;
        check("bad_cnt_pre", {16'b0, saved_cnt}, 32'd3);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        step(3);
        check("halt_no_push", {16'b0, fetch_count}, 32'd3);
        check("halt_valid", {31'b0, if_valid}, 32'h0);
        check("halt_err", {31'b0, fetch_err}, 32'h1);
        check("halt_done", {31'b0, fetch_done}, 32'h0);

        // out-of-range redirect halts
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h144;
        step(1);
        redirect_valid = 1'b0;
        check("oor_err", {31'b0, fetch_err}, 32'h1);

        // fetch limit
        do_reset();
        fetch_en = 1'b1; if_ready = 1'b1;
        last_pc = 32'hFFFF_FFFF;
        for (int k = 0; k < 200; k++) begin
            step(1);
            if (if_valid) last_pc = if_pc;
            if (fetch_done) break;
        end
        check("lim_done", {31'b0, fetch_done}, 32'h1);
        check("lim_last_pc", last_pc, 32'h140);
        check("lim_count", {16'b0, fetch_count}, 32'd81);
        check("lim_addr", imem_addr, 32'h144);
        step(1);
        check("lim_drain", {31'b0, if_valid}, 32'h0);
        check("lim_done_hold", {31'b0, fetch_done}, 32'h1);
        check("lim_count_hold", {16'b0, fetch_count}, 32'd81);

        // recovery from DONE
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        check("rec_done", {31'b0, fetch_done}, 32'h0);
        check("rec_flush", {31'b0, if_valid}, 32'h0);
        check("rec_addr", imem_addr, 32'h0);
        step(1);
        check("rec_pc", if_pc, 32'h0);
        check("rec_valid", {31'b0, if_valid}, 32'h1);
        check("rec_count", {16'b0, fetch_count}, 32'd82);
        fetch_en = 1'b0;
        step(2);
        check("idle_no_push", {16'b0, fetch_count}, 32'd82);
        check("idle_drain", {31'b0, if_valid}, 32'h0);

        // asynchronous reset mid-stream
        do_reset();
        fetch_en = 1'b1; if_ready = 1'b0;
        step(3);
        check("mid_full_valid", {31'b0, if_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", {31'b0, if_valid}, 32'h0);
        check("mid_async_addr", imem_addr, 32'h0);
        check("mid_async_count", {16'b0, fetch_count}, 32'h0);
        fetch_en = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        check("mid_rel_addr", imem_addr, 32'h0);
        check("mid_rel_valid", {31'b0, if_valid}, 32'h0);
        fetch_en = 1'b1;
        step(1);
        check("mid_first_pc", if_pc, 32'h0);
        check("mid_first_valid", {31'b0, if_valid}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
